// File: rtl/sap1_controller_if.sv
// Control bus between the SAP-1 sequencer and the datapath.
// The master side drives run/opcode; the slave side (the controller) drives the T-state and strobes.
interface sap1_controller_if;
  logic       run;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic       pc_out;
  logic       pc_inc;
  logic       mar_load;
  logic       ram_out;
  logic       ir_load;
  logic       ir_send;
  logic       acc_load;
  logic       acc_out;
  logic       b_load;
  logic       out_load;
  logic       alu_sub;
  logic       alu_out;
  logic       halted;

  modport master (
    output run, opcode,
    input  t_state, pc_out, pc_inc, mar_load, ram_out, ir_load, ir_send,
           acc_load, acc_out, b_load, out_load, alu_sub, alu_out, halted
  );

  modport slave (
    input  run, opcode,
    output t_state, pc_out, pc_inc, mar_load, ram_out, ir_load, ir_send,
           acc_load, acc_out, b_load, out_load, alu_sub, alu_out, halted
  );
endinterface

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: six-state one-hot T ring plus a HALT state,
// with strobes decoded live from the current T-state and opcode.
module sap1_controller (
  input  logic               clk,
  input  logic               reset,
  sap1_controller_if.slave   bus
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // State encoding doubles as the t_state output; HALT is the all-zero code.
  typedef enum logic [5:0] {
    S_HALT = 6'b000000,
    S_T1   = 6'b000001,
    S_T2   = 6'b000010,
    S_T3   = 6'b000100,
    S_T4   = 6'b001000,
    S_T5   = 6'b010000,
    S_T6   = 6'b100000
  } state_t;

  state_t r_state;
  logic   w_active;
  logic   w_isSub;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_T1;
    end else if (bus.run) begin
      case (r_state)
        S_T1:    r_state <= S_T2;
        S_T2:    r_state <= S_T3;
        S_T3:    r_state <= S_T4;
        S_T4:    r_state <= (bus.opcode == OP_HLT) ? S_HALT : S_T5;
        S_T5:    r_state <= S_T6;
        S_T6:    r_state <= S_T1;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_T1;
      endcase
    end
  end

  // Reset is folded in so no strobe can glitch out between reset assertion and the state update.
  assign w_active     = bus.run && !reset && (r_state != S_HALT);
  assign w_isSub      = (bus.opcode == OP_SUB);
  assign bus.t_state  = r_state;
  assign bus.halted   = (r_state == S_HALT);

  always_comb begin
    bus.pc_out   = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.mar_load = 1'b0;
    bus.ram_out  = 1'b0;
    bus.ir_load  = 1'b0;
    bus.ir_send  = 1'b0;
    bus.acc_load = 1'b0;
    bus.acc_out  = 1'b0;
    bus.b_load   = 1'b0;
    bus.out_load = 1'b0;
    bus.alu_sub  = 1'b0;
    bus.alu_out  = 1'b0;
    if (w_active) begin
      case (r_state)
        S_T1: begin
          bus.pc_out   = 1'b1;
          bus.mar_load = 1'b1;
        end
        S_T2: bus.pc_inc = 1'b1;
        S_T3: begin
          bus.ram_out = 1'b1;
          bus.ir_load = 1'b1;
        end
        S_T4: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              bus.ir_send  = 1'b1;
              bus.mar_load = 1'b1;
            end
            OP_OUT: begin
              bus.acc_out  = 1'b1;
              bus.out_load = 1'b1;
            end
            default: ;
          endcase
        end
        S_T5: begin
          case (bus.opcode)
            OP_LDA: begin
              bus.ram_out  = 1'b1;
              bus.acc_load = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              bus.ram_out = 1'b1;
              bus.b_load  = 1'b1;
              bus.alu_sub = w_isSub;
            end
            default: ;
          endcase
        end
        S_T6: begin
          case (bus.opcode)
            OP_ADD, OP_SUB: begin
              bus.alu_out  = 1'b1;
              bus.acc_load = 1'b1;
              bus.alu_sub  = w_isSub;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
